sliding_window_buffer: RTL and testbench

SLIDING_WINDOW_BUFFER -- requirements
Module: sliding_window_buffer

---
 rtl/buffer_pkg.sv | 21 ++
 rtl/sliding_window_buffer_if.sv | 31 +++
 rtl/window_bank.sv | 30 +++
 rtl/sliding_window_buffer.sv | 163 ++++++++++++++++
 tb/tb_sliding_window_buffer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_pkg.sv
// Sliding window buffer: shared sizing helpers.
// Window length and counter/address widths derived from parameters.
package buffer_pkg;

  function automatic int tot_size(int batch, int runs, int stride);
    return batch + (runs - 1) * stride;
  endfunction

  function automatic int cnt_width(int n);
    return $clog2(n + 1);
  endfunction

  function automatic int addr_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int batch_width(int runs);
    return (runs > 1) ? $clog2(runs) : 1;
  endfunction

endpackage

// File: rtl/sliding_window_buffer_if.sv
// Sliding window buffer: sink and source stream signals.
// slave = buffer side, master = producer/consumer side.
interface sliding_window_buffer_if #(
  parameter int DW = 16,
  parameter int BW = 2
);
  logic          sink_valid;
  logic          sink_ready;
  logic [DW-1:0] sink_data;
  logic          source_valid;
  logic          source_ready;
  logic          source_sop;
  logic          source_eop;
  logic          source_last;
  logic [BW-1:0] source_batch;
  logic [DW-1:0] source_data;

  modport master (
    output sink_valid, sink_data, source_ready,
    input  sink_ready, source_valid, source_sop,
    input  source_eop, source_last, source_batch,
    input  source_data
  );

  modport slave (
    input  sink_valid, sink_data, source_ready,
    output sink_ready, source_valid, source_sop,
    output source_eop, source_last, source_batch,
    output source_data
  );
endinterface

// File: rtl/window_bank.sv
// One window bank: single write port, registered read port.
// Read register only loads on re_i so it doubles as the output data register.
module window_bank #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sliding_window_buffer.sv
// Ping-pong window buffer: fills one bank while draining the
// other as RUNS overlapping batches of BATCH_SIZE entries.
module sliding_window_buffer
  import buffer_pkg::*;
#(
  parameter int BATCH_SIZE = 8,
  parameter int RUNS       = 4,
  parameter int STRIDE     = 1,
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 1
) (
  input logic sink_clk,
  input logic reset,
  sliding_window_buffer_if.slave bus
);
  localparam int TOT = tot_size(BATCH_SIZE, RUNS, STRIDE);
  localparam int PW  = cnt_width(TOT);
  localparam int AW  = addr_width(TOT);
  localparam int BW  = batch_width(RUNS);
  localparam int DW  = CHANNELS * DATA_WIDTH;

  logic [1:0]    full_q, full_d;
  logic          fill_sel_q, fill_sel_d;
  logic          drain_sel_q, drain_sel_d;
  logic          out_sel_q, out_sel_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] base_q, base_d;
  logic [PW-1:0] ent_q, ent_d;
  logic [BW-1:0] batch_q, batch_d;
  logic [BW-1:0] obatch_q, obatch_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          last_q, last_d;

  logic          sink_acc, wrap, ld, go, rel;
  logic          ent_end, bat_end;
  logic [1:0]    we, re;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] rdata [2];

  assign bus.sink_ready = !full_q[fill_sel_q];
  assign sink_acc = bus.sink_valid && !full_q[fill_sel_q];
  assign wrap     = wptr_q == PW'(TOT - 1);
  assign ld       = !valid_q || bus.source_ready;
  assign go       = ld && full_q[drain_sel_q];
  assign rel      = valid_q && bus.source_ready
                    && last_q && eop_q;
  assign ent_end  = ent_q == PW'(BATCH_SIZE - 1);
  assign bat_end  = batch_q == BW'(RUNS - 1);
  assign waddr    = AW'(wptr_q);
  assign raddr    = AW'(base_q + ent_q);
  assign we = {sink_acc && fill_sel_q,
               sink_acc && !fill_sel_q};
  assign re = {go && drain_sel_q,
               go && !drain_sel_q};

  // Release (out_sel_q) and completion (fill_sel_q) never hit the same bank.
  always_comb begin
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    wptr_d     = wptr_q;
    if (rel) full_d[out_sel_q] = 1'b0;
    if (sink_acc) begin
      wptr_d = wrap ? '0 : wptr_q + 1'b1;
      if (wrap) begin
        full_d[fill_sel_q] = 1'b1;
        fill_sel_d = !fill_sel_q;
      end
    end
  end

  // Drain pointer moves on load; the full flag waits for acceptance.
  always_comb begin
    drain_sel_d = drain_sel_q;
    out_sel_d   = out_sel_q;
    base_d      = base_q;
    ent_d       = ent_q;
    batch_d     = batch_q;
    obatch_d    = obatch_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    last_d      = last_q;
    if (ld) begin
      valid_d = go;
      sop_d   = go && ent_q == '0;
      eop_d   = go && ent_end;
      last_d  = go && bat_end;
    end
    if (go) begin
      obatch_d  = batch_q;
      out_sel_d = drain_sel_q;
      ent_d     = ent_q + 1'b1;
      if (ent_end) begin
        ent_d   = '0;
        base_d  = base_q + PW'(STRIDE);
        batch_d = batch_q + 1'b1;
        if (bat_end) begin
          base_d      = '0;
          batch_d     = '0;
          drain_sel_d = !drain_sel_q;
        end
      end
    end
  end

  always_ff @(posedge sink_clk) begin
    if (reset) begin
      full_q      <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      out_sel_q   <= 1'b0;
      wptr_q      <= '0;
      base_q      <= '0;
      ent_q       <= '0;
      batch_q     <= '0;
      obatch_q    <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      full_q      <= full_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      out_sel_q   <= out_sel_d;
      wptr_q      <= wptr_d;
      base_q      <= base_d;
      ent_q       <= ent_d;
      batch_q     <= batch_d;
      obatch_q    <= obatch_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      last_q      <= last_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    window_bank #(
      .DEPTH(TOT),
      .WIDTH(DW),
      .AW   (AW)
    ) u_bank (
      .clk_i  (sink_clk),
      .rst_i  (reset),
      .we_i   (we[i]),
      .waddr_i(waddr),
      .wdata_i(bus.sink_data),
      .re_i   (re[i]),
      .raddr_i(raddr),
      .rdata_o(rdata[i])
    );
  end

  assign bus.source_valid = valid_q;
  assign bus.source_sop   = sop_q;
  assign bus.source_eop   = eop_q;
  assign bus.source_last  = last_q;
  assign bus.source_batch = obatch_q;
  assign bus.source_data  = rdata[out_sel_q];
endmodule

// File: tb/tb_sliding_window_buffer.sv
// Directed bench for sliding_window_buffer: 4/3/2 x2 lanes
// plus a 1/1/1 instance.
module tb_sliding_window_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int ncmp = 0;
  int nerr = 0;
  int pushed, got, gcyc;
  int drop_early, gaps, rel_cyc, rise_cyc;
  logic seen;
  logic [7:0] base;

  always #5 clk = ~clk;

  sliding_window_buffer_if #(.DW(16), .BW(2)) ia ();
  sliding_window_buffer_if #(.DW(16), .BW(1)) ib ();

  sliding_window_buffer #(
    .BATCH_SIZE(4), .RUNS(3), .STRIDE(2),
    .DATA_WIDTH(8), .CHANNELS(2)
  ) dut_a (
    .sink_clk(clk),
    .reset   (reset),
    .bus     (ia.slave)
  );

  sliding_window_buffer #(
    .BATCH_SIZE(1), .RUNS(1), .STRIDE(1),
    .DATA_WIDTH(8), .CHANNELS(2)
  ) dut_b (
    .sink_clk(clk),
    .reset   (reset),
    .bus     (ib.slave)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mkd(int i);
    logic [7:0] b;
    b = base + 8'(i);
    return {~b, b};
  endfunction

  // beat k of the window stream: {sop,eop,last,batch,data}
  function automatic logic [31:0] exp_a(int k);
    int w, j, p;
    logic [7:0] b;
    w = k / 12;
    j = k % 12;
    p = (j / 4) * 2 + j % 4;
    b = base + 8'(w * 8 + p);
    return {11'd0, (j % 4 == 0), (j % 4 == 3),
            (j / 4 == 2), 2'(j / 4), ~b, b};
  endfunction

  task automatic clear();
    pushed = 0;
    got = 0;
    drop_early = 0;
    gaps = 0;
    rel_cyc = -1;
    rise_cyc = -1;
    seen = 1'b0;
  endtask

  task automatic reset_check(string tag);
    ia.sink_valid = 1'b0;
    ia.source_ready = 1'b0;
    ib.sink_valid = 1'b0;
    ib.source_ready = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_out"},
        {10'd0, ia.source_valid, ia.source_sop,
         ia.source_eop, ia.source_last,
         ia.source_batch, ia.source_data}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_rdy"}, 32'(ia.sink_ready), 32'd1);
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 ready low
  task automatic run_a(int npush, int mode,
                       int nout, int maxcyc);
    int c;
    logic sacc, oacc;
    c = 0;
    while (c < maxcyc && (nout == 0 || got < nout)) begin
      ia.sink_valid = (pushed < npush);
      ia.sink_data = mkd(pushed);
      case (mode)
        0: ia.source_ready = 1'b1;
        1: ia.source_ready = (c % 2 == 0);
        default: ia.source_ready = 1'b0;
      endcase
      #1;
      sacc = ia.sink_valid && ia.sink_ready;
      oacc = ia.source_valid && ia.source_ready;
      if (ia.sink_valid && !ia.sink_ready && pushed < 16)
        drop_early++;
      if (pushed == 16 && ia.sink_ready && rise_cyc < 0)
        rise_cyc = gcyc;
      if (seen && !ia.source_valid && got < nout)
        gaps++;
      if (ia.source_valid) begin
        seen = 1'b1;
        chk("beat",
            {11'd0, ia.source_sop, ia.source_eop,
             ia.source_last, ia.source_batch,
             ia.source_data}, exp_a(got));
      end
      if (oacc && got == 11) rel_cyc = gcyc;
      @(posedge clk);
      #1;
      pushed += int'(sacc);
      got += int'(oacc);
      c++;
      gcyc++;
    end
    if (nout > 0) chk("done", got, nout);
  endtask

  task automatic run_b(int n, int maxcyc);
    int pb, gb, c;
    logic sacc, oacc;
    pb = 0;
    gb = 0;
    c = 0;
    ib.source_ready = 1'b1;
    while (gb < n && c < maxcyc) begin
      ib.sink_valid = (pb < n);
      ib.sink_data = mkd(pb);
      #1;
      sacc = ib.sink_valid && ib.sink_ready;
      oacc = ib.source_valid && ib.source_ready;
      if (ib.source_valid)
        chk("b1_beat",
            {12'd0, ib.source_sop, ib.source_eop,
             ib.source_last, ib.source_batch,
             ib.source_data},
            {12'd0, 4'b1110, mkd(gb)});
      @(posedge clk);
      #1;
      pb += int'(sacc);
      gb += int'(oacc);
      c++;
    end
    ib.sink_valid = 1'b0;
    chk("b1_done", 32'(gb), 32'(n));
  endtask

  initial begin
    gcyc = 0;
    base = 8'h00;
    ia.sink_data = '0;
    ib.sink_data = '0;
    clear();

    reset_check("rst0");
    chk("rst0_b_out",
        {11'd0, ib.source_valid, ib.source_sop,
         ib.source_eop, ib.source_last,
         ib.source_batch, ib.source_data}, 32'd0);
    chk("rst0_b_rdy", 32'(ib.sink_ready), 32'd1);

    // single window, lane0 = 0..7
    clear();
    run_a(8, 0, 12, 60);

    // two windows back to back, no bubbles
    reset_check("rst1");
    clear();
    base = 8'h10;
    run_a(16, 0, 24, 80);
    chk("no_early_drop", drop_early, 0);
    chk("no_gap", gaps, 0);

    // downstream toggling
    reset_check("rst2");
    clear();
    base = 8'h20;
    run_a(8, 1, 12, 80);

    // downstream blocked: both banks fill
    reset_check("rst3");
    clear();
    base = 8'h50;
    run_a(17, 2, 0, 30);
    chk("blk_pushed", pushed, 16);
    chk("blk_rdy_low", 32'(ia.sink_ready), 32'd0);
    run_a(17, 0, 24, 100);
    chk("blk_pushed17", pushed, 17);
    chk("blk_no_early_drop", drop_early, 0);
    chk("blk_rise", rise_cyc, rel_cyc + 1);

    // reset with a half-filled window
    reset_check("rst4");
    clear();
    base = 8'h60;
    run_a(5, 0, 0, 5);
    chk("part_pushed", pushed, 5);
    reset_check("rst5");

    // reset mid-drain
    clear();
    base = 8'h70;
    run_a(8, 0, 6, 60);
    reset_check("rst6");

    // fresh window after resets
    clear();
    base = 8'h40;
    run_a(8, 0, 12, 60);

    // degenerate 1/1/1 instance
    ia.sink_valid = 1'b0;
    ia.source_ready = 1'b0;
    base = 8'h30;
    run_b(5, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
